// File: rtl/text_buffer.sv
// text_buffer: character-grid screen memory fed by a UART byte stream.
// Printable ASCII is written at the cursor. The control codes newline,
// carriage return, backspace and form-feed move the cursor and clear cells.
// The renderer reads the grid through a registered read port.
// Optional feature: define TEXTBUF_SCROLL_EN to scroll the screen up on a
// newline at the bottom row. Without it, the cursor wraps to the top row.
module text_buffer #(
  parameter int COLS   = 16,
  parameter int ROWS   = 4,
  parameter int ADDR_W = $clog2(COLS*ROWS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [7:0]              rd_data,
  output logic [$clog2(COLS)-1:0] cursor_col,
  output logic [$clog2(ROWS)-1:0] cursor_row,
  output logic                    busy,
  output logic                    frame_update,
  output logic                    overflow
);
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam int CELLS = COLS*ROWS;
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS-1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS-1);
  localparam logic [ROW_W:0]    ROWS_EXT  = (ROW_W+1)'(ROWS);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS-1);
  localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(COLS-1);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);

  typedef enum logic [1:0] {CLEAR_ALL, IDLE, CLEAR_LINE} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] cnt, cnt_next;
  logic [COL_W-1:0]  col, col_next;
  logic [ROW_W-1:0]  row, row_next;
  logic [ROW_W-1:0]  top_row, top_next;
  logic [ROW_W-1:0]  clr_row, clr_next;
  logic              fu_next;
  logic              rx_valid_q, accept, consume, newline;
  logic [7:0]        pend;
  logic              pend_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [ROW_W-1:0]  rd_lrow;
  logic [COL_W-1:0]  rd_col;
  logic [ADDR_W-1:0] rd_phys;
  logic [7:0]        mem [CELLS];

  // Logical row to physical row: the ring of lines starts at top_row.
  // A compare-subtract keeps this correct for any ROWS, including non-powers of two.
  function automatic logic [ROW_W-1:0] wrap_row(input logic [ROW_W-1:0] lrow,
                                                input logic [ROW_W-1:0] top);
    logic [ROW_W:0] sum;
    sum = {1'b0, lrow} + {1'b0, top};
    if (sum >= ROWS_EXT) sum = sum - ROWS_EXT;
    return sum[ROW_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] prow,
                                                  input logic [COL_W-1:0] c);
    return ADDR_W'(prow) * COLS_A + ADDR_W'(c);
  endfunction

  assign accept     = rx_valid & ~rx_valid_q;
  assign busy       = (state != IDLE);
  assign cursor_col = col;
  assign cursor_row = row;

  assign rd_lrow = ROW_W'(rd_addr / COLS_A);
  assign rd_col  = COL_W'(rd_addr % COLS_A);
  assign rd_phys = cell_addr(wrap_row(rd_lrow, top_row), rd_col);

  // Screen memory write port; contents need no reset because CLEAR_ALL follows reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port; a same-cycle write to the same cell returns the old value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= 8'h00;
    else        rd_data <= mem[rd_phys];
  end

  // Edge-detect the receiver strobe and hold one byte until the FSM takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q <= 1'b1;
      pend       <= 8'h00;
      pend_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      if (accept) begin
        if (!pend_valid || consume) begin
          pend       <= rx_data;
          pend_valid <= 1'b1;
        end else begin
          overflow   <= 1'b1;
        end
      end else if (consume) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // State, cursor and scroll-origin registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= CLEAR_ALL;
      cnt          <= '0;
      col          <= '0;
      row          <= '0;
      top_row      <= '0;
      clr_row      <= '0;
      frame_update <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      col          <= col_next;
      row          <= row_next;
      top_row      <= top_next;
      clr_row      <= clr_next;
      frame_update <= fu_next;
    end
  end

  // Byte interpretation and clear sequencing
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    col_next   = col;
    row_next   = row;
    top_next   = top_row;
    clr_next   = clr_row;
    fu_next    = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = cell_addr(wrap_row(row, top_row), col);
    wr_data    = 8'h20;
    consume    = 1'b0;
    newline    = 1'b0;
    case (state)
      CLEAR_ALL: begin
        wr_en   = 1'b1;
        wr_addr = cnt;
        if (cnt == LAST_CELL) begin
          state_next = IDLE;
          cnt_next   = '0;
          fu_next    = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      CLEAR_LINE: begin
        wr_en   = 1'b1;
        wr_addr = cell_addr(clr_row, COL_W'(cnt));
        if (cnt == LAST_LINE) begin
          state_next = IDLE;
          cnt_next   = '0;
          fu_next    = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        if (pend_valid) begin
          consume = 1'b1;
          if (pend >= 8'h20 && pend <= 8'h7E) begin
            wr_en   = 1'b1;
            wr_data = pend;
            fu_next = 1'b1;
            if (col == LAST_COL) newline = 1'b1;
            else                 col_next = col + 1'b1;
          end else if (pend == 8'h0A || pend == 8'h0D) begin
            newline = 1'b1;
            fu_next = 1'b1;
          end else if (pend == 8'h08 || pend == 8'h7F) begin
            wr_en   = 1'b1;
            fu_next = 1'b1;
            if (col != '0) begin
              col_next = col - 1'b1;
            end else if (row != '0) begin
              row_next = row - 1'b1;
              col_next = LAST_COL;
            end
            wr_addr = cell_addr(wrap_row(row_next, top_row), col_next);
          end else if (pend == 8'h0C) begin
            col_next   = '0;
            row_next   = '0;
            cnt_next   = '0;
            state_next = CLEAR_ALL;
          end
          if (newline) begin
            col_next = '0;
            if (row != LAST_ROW) begin
              row_next = row + 1'b1;
            end else begin
              // The refresh pulse is deferred until the new bottom line is blank
              fu_next    = 1'b0;
              cnt_next   = '0;
              state_next = CLEAR_LINE;
`ifdef TEXTBUF_SCROLL_EN
              top_next = (top_row == LAST_ROW) ? '0 : top_row + 1'b1;
              clr_next = top_row;
`else
              row_next = '0;
              clr_next = '0;
`endif
            end
          end
        end
      end
    endcase
  end
endmodule

// File: tb/tb_text_buffer.sv
// Testbench for text_buffer. Stimulus pushes expected results into a
// scoreboard queue. A monitor pops each entry one cycle later and compares
// it with the DUT output. Expectations follow TEXTBUF_SCROLL_EN.
`timescale 1ns/1ps
module tb_text_buffer;
  localparam int COLS   = 16;
  localparam int ROWS   = 4;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [7:0]        rd_data;
  logic [3:0]        cursor_col;
  logic [1:0]        cursor_row;
  logic              busy, frame_update, overflow;

  text_buffer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rd_addr(rd_addr), .rd_data(rd_data), .cursor_col(cursor_col),
    .cursor_row(cursor_row), .busy(busy), .frame_update(frame_update),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // kind: 0 rd_data, 1 cursor_col, 2 cursor_row, 3 busy, 4 overflow,
  //       5 frame_update pulses since base, 6 measured clear length, 7 frame_update
  typedef struct {
    string name;
    int    kind;
    int    exp;
    int    base;
  } chk_t;

  chk_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   fu_cnt = 0;
  int   fu_base = 0;
  int   clr_cycles = 0;
  logic chk_req = 1'b0;
  logic chk_due = 1'b0;

  always @(posedge clk) if (frame_update) fu_cnt <= fu_cnt + 1;
  always @(posedge clk) chk_due <= chk_req;

  function automatic int actual_of(input int kind, input int base);
    case (kind)
      0:       return int'(rd_data);
      1:       return int'(cursor_col);
      2:       return int'(cursor_row);
      3:       return int'(busy);
      4:       return int'(overflow);
      5:       return fu_cnt - base;
      6:       return clr_cycles;
      default: return int'(frame_update);
    endcase
  endfunction

  // Monitor: one scoreboard entry falls due one cycle after it was issued
  always @(negedge clk) begin
    if (chk_due) begin
      checks <= checks + 1;
      if (sb.size() == 0) begin
        errors <= errors + 1;
        $display("FAIL scoreboard_empty: got no entry, required one");
      end else begin
        if (actual_of(sb[0].kind, sb[0].base) != sb[0].exp) begin
          errors <= errors + 1;
          $display("FAIL %s: got 0x%0h, required 0x%0h", sb[0].name,
                   actual_of(sb[0].kind, sb[0].base), sb[0].exp);
        end else begin
          $display("check %s: 0x%0h ok", sb[0].name, sb[0].exp);
        end
        void'(sb.pop_front());
      end
    end
  end

  task automatic expect_val(input string name, input int kind, input int exp);
    sb.push_back('{name, kind, exp, fu_base});
    chk_req = 1'b1;
    @(negedge clk);
    chk_req = 1'b0;
  endtask

  task automatic rd(input int addr, input int exp, input string name);
    rd_addr = ADDR_W'(addr);
    expect_val(name, 0, exp);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    $display("sent byte 0x%0h", b);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    expect_val("idle", 3, 0);
  endtask

  task automatic measure_clear();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    clr_cycles = n;
  endtask

  task automatic reset_checks(input string tag);
    expect_val({tag, "_rd_data"}, 0, 0);
    expect_val({tag, "_col"}, 1, 0);
    expect_val({tag, "_row"}, 2, 0);
    expect_val({tag, "_busy"}, 3, 1);
    expect_val({tag, "_overflow"}, 4, 0);
    expect_val({tag, "_frame_update"}, 7, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with rx_valid already high: it must not yield a byte
    rst_n    = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'h41;
    repeat (3) @(negedge clk);
    fu_base = fu_cnt;
    reset_checks("rst");
    expect_val("rst_fu_count", 5, 0);

    // Power-up clear: 64 cycles of busy, one refresh pulse, all cells blank
    @(negedge clk);
    rst_n   = 1'b1;
    fu_base = fu_cnt;
    measure_clear();
    expect_val("clear_cycles", 6, 64);
    repeat (2) @(negedge clk);
    expect_val("clear_fu_count", 5, 1);
    rx_valid = 1'b0;
    @(negedge clk);
    expect_val("no_byte_at_reset_col", 1, 0);
    for (int i = 0; i < COLS*ROWS; i++) rd(i, 'h20, "clear_cell");

    // "AB"
    fu_base = fu_cnt;
    send(8'h41);
    send(8'h42);
    rd(0, 'h41, "ab_cell0");
    rd(1, 'h42, "ab_cell1");
    expect_val("ab_col", 1, 2);
    expect_val("ab_row", 2, 0);
    expect_val("ab_fu_count", 5, 2);

    // Form-feed followed by three bytes during the clear
    send(8'h0C);
    send(8'h51);
    send(8'h52);
    send(8'h53);
    wait_idle();
    expect_val("ovf_flag", 4, 1);
    expect_val("ovf_col", 1, 1);
    expect_val("ovf_row", 2, 0);
    rd(0, 'h51, "ovf_cell0");
    rd(1, 'h20, "ovf_cell1");

    // 17 x then two backspaces
    send(8'h0C);
    wait_idle();
    for (int i = 0; i < 17; i++) send(8'h78);
    send(8'h08);
    send(8'h08);
    expect_val("bs_col", 1, 15);
    expect_val("bs_row", 2, 0);
    rd(0, 'h78, "bs_cell0");
    rd(14, 'h78, "bs_cell14");
    rd(15, 'h20, "bs_cell15");
    rd(16, 'h20, "bs_cell16");

    // Unknown control code: no change and no refresh
    fu_base = fu_cnt;
    send(8'h01);
    @(negedge clk);
    expect_val("ign_fu_count", 5, 0);
    expect_val("ign_col", 1, 15);

    // Backspace at the home position stays put
    send(8'h0C);
    wait_idle();
    send(8'h7F);
    expect_val("bs_home_col", 1, 0);
    expect_val("bs_home_row", 2, 0);

    // Four "Z\n" lines reach the end of the screen
    for (int k = 0; k < 4; k++) begin
      send(8'h5A);
      send(8'h0A);
    end
    wait_idle();
`ifdef TEXTBUF_SCROLL_EN
    rd(0, 'h5A, "scr_row0");
    rd(1, 'h20, "scr_row0_col1");
    rd(16, 'h5A, "scr_row1");
    rd(32, 'h5A, "scr_row2");
    for (int i = 48; i < 64; i++) rd(i, 'h20, "scr_bottom_blank");
    expect_val("scr_col", 1, 0);
    expect_val("scr_row", 2, 3);
`else
    for (int i = 0; i < 16; i++) rd(i, 'h20, "wrap_row0_blank");
    rd(16, 'h5A, "wrap_row1");
    rd(32, 'h5A, "wrap_row2");
    rd(48, 'h5A, "wrap_row3");
    expect_val("wrap_col", 1, 0);
    expect_val("wrap_row", 2, 0);
`endif

    // Reset in the middle of a line clear
    for (int k = 0; k < ROWS && cursor_row != 2'd3; k++) send(8'h0A);
    send(8'h0A);
    expect_val("line_busy", 3, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    reset_checks("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    measure_clear();
    expect_val("reclear_cycles", 6, 64);
    rd(0, 'h20, "reclear_cell0");
    rd(16, 'h20, "reclear_cell16");
    rd(48, 'h20, "reclear_cell48");

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/text_buffer.md
# text_buffer

Character-grid text buffer sitting directly downstream of the UART receiver. Consumes received bytes, interprets printable ASCII and a small set of control codes, and maintains a COLS×ROWS screen memory plus cursor. The OLED renderer reads the grid through a registered random-access read port and redraws on `frame_update`.

## Interface
- `COLS`, 16: characters per row (≥2).
- `ROWS`, 4: visible rows (≥2).
- `ADDR_W`, `$clog2(COLS*ROWS)`: read address width.
- `clk` input 1: system clock.
- `rst_n` input 1: one clock; reset is asynchronous and active-low.
- `rx_data` input 8: byte from UART receiver.
- `rx_valid` input 1: receiver valid flag. May be level or pulse; only a rising edge is sampled.
- `rd_addr` input ADDR_W: logical address, row*COLS+col, row 0 = top of screen.
- `rd_data` output 8: character at `rd_addr`.
- `cursor_col` output $clog2(COLS): current column.
- `cursor_row` output $clog2(ROWS): current logical row.
- `busy` output 1: clear/line-clear sequencer active.
- `frame_update` output 1: one-cycle pulse after any grid or cursor change.
- `overflow` output 1: sticky, a byte was dropped.

## Operation
- Edge detect: registered copy of `rx_valid`; byte accepted when `rx_valid & ~rx_valid_q`. Accepted byte goes to a one-deep pending register.
- States: CLEAR_ALL, IDLE, CLEAR_LINE.
- IDLE consumes the pending byte:
  - 0x20–0x7E: write at cursor; col+1. At col COLS-1, go to col 0 of next line (newline rule).
  - 0x0A or 0x0D: newline. col=0. If row<ROWS-1, row+1. Otherwise apply the end-of-screen rule (Configuration) and enter CLEAR_LINE.
  - 0x08 or 0x7F: backspace. If col>0, col-1. Else if row>0, go to row-1, col COLS-1. Else no-op. The resulting cell is written 0x20.
  - 0x0C: cursor to (0,0), enter CLEAR_ALL.
  - Other codes: ignored, no `frame_update`.
- CLEAR_ALL writes 0x20 to every physical cell, one per cycle, address 0 upward. It is entered on reset release, so memory needs no reset.
- CLEAR_LINE writes 0x20 to the COLS cells of the new bottom line.
- Busy/pending rules:
  - Bytes arriving while `busy` are held in the pending register and processed on the return to IDLE.
  - If a byte arrives while pending is full and not consumed in the same cycle, the new byte is dropped and `overflow` is set.
  - Accept and consume in the same cycle is legal; no drop.
- Physical row = (logical row + top_row) mod ROWS, computed by compare-subtract, so any ROWS is legal. Applies to both the write path and the read path.

## Timing
- Reset values: `rd_data`=0x00, cursor=(0,0), top_row=0, `busy`=1 (CLEAR_ALL starts on first edge after release), `frame_update`=0, `overflow`=0, `rx_valid_q`=1.
  - `rx_valid_q`=1 means a `rx_valid` already high at reset does not produce a byte.
- Rising edge of `rx_valid` seen at clock N: pending loaded at N. If IDLE, the memory write, cursor update and `frame_update` all land at N+1.
- CLEAR_ALL lasts COLS*ROWS cycles; CLEAR_LINE lasts COLS cycles.
  - `busy` rises on the cycle the state is entered and falls on the cycle after the last write.
  - `frame_update` pulses once, on the cycle after the last write.
- Read port: `rd_data` is valid one cycle after `rd_addr`. The read port is independent of writes.
- Read during write to the same cell returns old data.
- `rst_n` assertion mid-sequence aborts immediately. All registers return to reset values, and CLEAR_ALL restarts on release.

## Configuration
- `TEXTBUF_SCROLL_EN` defined (end-of-screen rule):
  - Newline on row ROWS-1 increments top_row (mod ROWS) and keeps the cursor on row ROWS-1.
  - The old top line becomes the new bottom line, which is cleared, so content scrolls up by one line.
- `TEXTBUF_SCROLL_EN` undefined: top_row is held at 0; cursor wraps to row 0, col 0, and row 0 is cleared.

## Test plan
- Reset, wait 64 cycles (COLS=16, ROWS=4): `busy` low at cycle 65, a single `frame_update` pulse, all 64 reads return 0x20.
- Bytes "AB" as rx_valid pulses: reads of addr 0 and 1 give 0x41 and 0x42; cursor=(2,0); two `frame_update` pulses.
- 17 × 'x' then 0x08 0x08: cells 0–15 and 16 are 'x'; backspaces leave cells 15 and 16 blank; cursor=(15,0).
- 4 × "Z\n" with SCROLL_EN: addr 0 reads 'Z' (row 0 holds the second 'Z'), addr 48–63 read 0x20, cursor=(0,3). Without SCROLL_EN: cursor=(0,0), row 0 blank, rows 1–3 'Z'.
- 0x0C immediately followed by three bytes during `busy`: first extra byte processed after clear, second and third dropped, `overflow`=1.
- `rst_n` pulsed low mid CLEAR_LINE: outputs at reset values, `busy`=1, full 64-cycle clear reruns.
